mult8_shift_add: RTL and testbench
==================================

// Module: mult8_shift_add
// PURPOSE
//  Sequential 8x8 unsigned shift-and-add multiplier; one partial product per clock.
//  Sits directly downstream of the 8-bit ripple adder adder8_fa: drives its a/b
//  inputs each cycle, consumes sum/cout into a shifting 16-bit accumulator.
//  Start/busy/done handshake; 16-bit registered product.
// PARAMETERS
//  WIDTH        8   operand width; fixed by adder8_fa; 8 is the only supported value
//  DONE_STICKY  0   0: done is a 1-cycle pulse; 1: done holds until next accepted start
// PORTS
//  clk      in   1   single clock, rising edge
//  rst_n    in   1   asynchronous, active-low reset
//  start    in   1   request; sampled only in IDLE or DONE state
//  a        in   8   multiplicand, captured with accepted start
//  b        in   8   multiplier, captured with accepted start
//  busy     out  1   high while state==CALC
//  done     out  1   result valid strobe (see DONE_STICKY)
//  product  out  16  a*b; updated only on CALC->DONE edge, otherwise held
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, busy=0, done=0, product=16'h0000, all regs 0.
//  - Regs: mcand[7:0], acc_hi[7:0], acc_lo[7:0] (holds multiplier), cnt[2:0].
//  - FSM IDLE -> CALC -> DONE -> (IDLE | CALC).
//    IDLE: start=1 -> mcand<=a, acc_hi<=0, acc_lo<=b, cnt<=0, go CALC.
//    CALC: step per cycle: if acc_lo[0] {c,s}=acc_hi+mcand (adder, cin=0) else {c,s}={0,acc_hi};
//          {acc_hi,acc_lo}<={c,s,acc_lo[7:1]}; cnt<=cnt+1. On cnt==7: product<={c,s,acc_lo[7:1]},
//          go DONE. start ignored in CALC (no queueing, no restart).
//    DONE: done=1. start=1 -> load as IDLE, go CALC (back-to-back, no idle cycle);
//          else DONE_STICKY=0 -> IDLE; DONE_STICKY=1 -> stay DONE, done held high.
//  - Latency: start sampled at edge 0 -> 8 CALC cycles -> done high in cycle 9 after start.
//  - Width: 8+8 add -> 9 bits (cout is bit 8); no overflow possible; max 0xFE01.
//  - Simultaneous start and done: done still asserted that cycle; product holds old value
//    until next CALC->DONE edge.
//  - Reset mid-CALC: aborts immediately, product cleared to 0, no done.
//  - a/b changes while busy have no effect.
// CONFIGURATION
//  MULT_ZERO_SKIP_EN defined: on accepted start with a==0 or b==0, skip CALC:
//    product<=0, go DONE directly (done 1 cycle after start).
//  Undefined: zero operands take the normal 8-cycle path; result still 0.
// STRUCTURE
//  - Shared package mult_pkg: state localparams ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2;
//    MULT_W=8, PROD_W=16, STEPS=8.
//  - One sub-module: adder8_fa instance (a=acc_hi, b=mcand); operand-select mux and
//    shift register stay in this module.
// TESTING
//  1 start, a=13, b=11 -> busy cycles 1-8, done cycle 9, product=16'h008F (143).
//  2 a=255, b=255 -> product=16'hFE01; a=1,b=128 -> 16'h0080; a=128,b=2 -> 16'h0100.
//  3 start re-pulsed with a=2,b=3 during CALC of 13*11 -> ignored, product=16'h008F.
//  4 start held high in DONE with a=7,b=6 -> no IDLE cycle, next done 9 cycles later, 16'h002A.
//  5 rst_n low at CALC cycle 4 -> busy=0, done=0, product=0 immediately; restart 5*5 -> 16'h0019.
//  6 a=0, b=200: MULT_ZERO_SKIP_EN -> done cycle 1, product=0; undefined -> done cycle 9, 0.
//  Run 2-6 with DONE_STICKY=0 and 1; check done width per setting; random 1000-pair
//  check vs a*b reference model.

Source files
------------

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared constants for the sequential shift-and-add multiplier.
//   ST_IDLE / ST_CALC / ST_DONE : FSM state encodings (2 bits)
//   MULT_W                      : operand width (8, set by the adder8_fa ripple adder)
//   PROD_W                      : product width (2 * MULT_W)
//   STEPS                       : partial products per multiply (one per clock)
// -----------------------------------------------------------------------------
package mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int MULT_W = 8;
  localparam int PROD_W = 16;
  localparam int STEPS  = 8;

endpackage

// File: rtl/adder8_fa.sv
// -----------------------------------------------------------------------------
// adder8_fa
// 8-bit ripple-carry adder built from a chain of full-adder cells.
// Ports:
//   a    in  8  addend
//   b    in  8  addend
//   cin  in  1  carry in
//   sum  out 8  a + b + cin, low 8 bits
//   cout out 1  carry out (bit 8 of the sum)
// -----------------------------------------------------------------------------
module adder8_fa
  import mult_pkg::*;
(
  input  logic [MULT_W-1:0] a,
  input  logic [MULT_W-1:0] b,
  input  logic              cin,
  output logic [MULT_W-1:0] sum,
  output logic              cout
);

  // c[i] is the carry into bit i; c[MULT_W] is the final carry out.
  logic [MULT_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < MULT_W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[MULT_W];

endmodule

// File: rtl/mult8_shift_add.sv
// -----------------------------------------------------------------------------
// mult8_shift_add
// Sequential 8x8 unsigned shift-and-add multiplier, one partial product per
// clock, feeding an adder8_fa instance every cycle.
//
// Handshake: a request is accepted on a rising clk edge where start=1 and the
// FSM is in IDLE or DONE; a/b are captured on that same edge. busy is high for
// the STEPS cycles of CALC, and start is ignored there. done is high while in
// DONE; product changes only on the CALC->DONE edge (or on a zero-skip load)
// and holds otherwise.
//
// Parameters:
//   WIDTH        operand width, only 8 is supported (adder8_fa is 8 bits)
//   DONE_STICKY  0: done is a one-cycle pulse; 1: done holds until next start
//
// Build option:
//   MULT_ZERO_SKIP_EN  when defined, an accepted start with a==0 or b==0 goes
//                      straight to DONE with product=0 (done one cycle later).
//
// Ports:
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        request
//   a        in   WIDTH    multiplicand
//   b        in   WIDTH    multiplier
//   busy     out  1        high while in CALC
//   done     out  1        result-valid strobe
//   product  out  2*WIDTH  registered a*b
// -----------------------------------------------------------------------------
module mult8_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit DONE_STICKY = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;   // multiplier bits, consumed LSB first
  logic [2:0]       cnt;

  logic             load;
  logic             zero_skip;
  logic             last_step;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH:0]   step;     // {carry, sum} of this cycle's partial add

  // A request is only seen in IDLE or DONE; DONE re-loads directly so
  // back-to-back multiplies have no idle cycle between them.
  assign load      = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_step = (cnt == 3'(STEPS - 1));

`ifdef MULT_ZERO_SKIP_EN
  assign zero_skip = (a == '0) || (b == '0);
`else
  assign zero_skip = 1'b0;
`endif

  adder8_fa u_adder (
    .a    (acc_hi),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Add the multiplicand only when the current multiplier bit is set;
  // otherwise pass the high half through with a zero carry.
  assign step = acc_lo[0] ? {add_cout, add_sum} : {1'b0, acc_hi};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = zero_skip ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        if (last_step) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start)             state_nxt = zero_skip ? ST_DONE : ST_CALC;
        else if (!DONE_STICKY) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_CALC: busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, shifting accumulator, product register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (load) begin
      mcand  <= a;
      acc_hi <= '0;
      acc_lo <= b;
      cnt    <= '0;
      if (zero_skip) product <= '0;
    end else if (state == ST_CALC) begin
      // The shift drops the multiplier bit just used and brings the adder
      // result in at the top.
      {acc_hi, acc_lo} <= {step, acc_lo[WIDTH-1:1]};
      cnt              <= cnt + 3'd1;
      if (last_step) product <= {step, acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_mult8_shift_add.sv
// -----------------------------------------------------------------------------
// tb_mult8_shift_add
// Two instances share stimulus: u_dut0 (DONE_STICKY=0) and u_dut1
// (DONE_STICKY=1). A monitor pops expected products from one queue per
// instance whenever that instance completes a multiply.
// -----------------------------------------------------------------------------
module tb_mult8_shift_add;

`ifdef MULT_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;

  logic        busy0, done0, busy1, done1;
  logic [15:0] product0, product1;

  always #5 clk = ~clk;

  mult8_shift_add #(.WIDTH(8), .DONE_STICKY(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .product(product0)
  );

  mult8_shift_add #(.WIDTH(8), .DONE_STICKY(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .product(product1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // start as the DUT saw it on the last rising edge
  logic start_q = 1'b0;
  always @(posedge clk) start_q <= start;

  // A completion is a cycle with done high that is either a fresh rise of done
  // or follows an accepted start while already in DONE.
  logic pd0 = 1'b0;
  logic pd1 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pd0 = 1'b0;
      pd1 = 1'b0;
    end else begin
      if (done0 && (!pd0 || start_q)) begin
        if (exp_q0.size() == 0) chk("dut0_unexpected_done", 32'd1, 32'd0);
        else chk("dut0_product", {16'd0, product0}, {16'd0, exp_q0.pop_front()});
      end
      if (done1 && (!pd1 || start_q)) begin
        if (exp_q1.size() == 0) chk("dut1_unexpected_done", 32'd1, 32'd0);
        else chk("dut1_product", {16'd0, product1}, {16'd0, exp_q1.pop_front()});
      end
      pd0 = done0;
      pd1 = done1;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Presents one request for one rising edge; pushes an expectation only when
  // the DUT is expected to accept it. Operands are scrambled afterwards so a
  // design that reads a/b while busy gets caught.
  task automatic drive_start(input logic [7:0] va, input logic [7:0] vb,
                             input logic [15:0] exp, input bit accepted);
    start = 1'b1;
    a     = va;
    b     = vb;
    if (accepted) begin
      exp_q0.push_back(exp);
      exp_q1.push_back(exp);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom_range(0, 255));
    b     = 8'($urandom_range(0, 255));
  endtask

  // Counts falling edges until dut0 shows done; bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (done0) return;
    end
    chk("wait_done_timeout", 32'd1, 32'd0);
  endtask

  function automatic int exp_lat(input logic [7:0] va, input logic [7:0] vb);
    return (SKIP && (va == 8'd0 || vb == 8'd0)) ? 1 : 9;
  endfunction

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    logic [7:0] ra, rb;

    vecs[0] = '{8'd13,  8'd11,  16'h008F};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd1,   8'd128, 16'h0080};
    vecs[3] = '{8'd128, 8'd2,   16'h0100};
    vecs[4] = '{8'd0,   8'd200, 16'h0000};
    vecs[5] = '{8'd200, 8'd0,   16'h0000};
    vecs[6] = '{8'd5,   8'd5,   16'h0019};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_busy0", {31'd0, busy0}, 32'd0);
    chk("reset_done0", {31'd0, done0}, 32'd0);
    chk("reset_product0", {16'd0, product0}, 32'd0);
    chk("reset_done1", {31'd0, done1}, 32'd0);
    chk("reset_product1", {16'd0, product1}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 13*11 with cycle-exact busy/done
    drive_start(8'd13, 8'd11, 16'h008F, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("t1_busy0_c%0d", i), {31'd0, busy0}, 32'd1);
      chk($sformatf("t1_done0_c%0d", i), {31'd0, done0}, 32'd0);
      chk($sformatf("t1_busy1_c%0d", i), {31'd0, busy1}, 32'd1);
    end
    @(negedge clk);
    chk("t1_done0_c9", {31'd0, done0}, 32'd1);
    chk("t1_busy0_c9", {31'd0, busy0}, 32'd0);
    chk("t1_done1_c9", {31'd0, done1}, 32'd1);
    @(negedge clk);
    chk("t1_done0_pulse", {31'd0, done0}, 32'd0);
    chk("t1_done1_sticky", {31'd0, done1}, 32'd1);
    chk("t1_product0_held", {16'd0, product0}, 32'h008F);

    // Table: latency, product (via monitor) and done width per setting
    for (int i = 0; i < 7; i++) begin
      drive_start(vecs[i].va, vecs[i].vb, vecs[i].exp, 1'b1);
      wait_done(lat);
      chk($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].va, vecs[i].vb));
      @(negedge clk);
      chk($sformatf("vec%0d_done0_width", i), {31'd0, done0}, 32'd0);
      chk($sformatf("vec%0d_done1_hold", i), {31'd0, done1}, 32'd1);
      chk($sformatf("vec%0d_product0_held", i), {16'd0, product0}, {16'd0, vecs[i].exp});
    end

    // Re-pulsed start during CALC is ignored
    drive_start(8'd13, 8'd11, 16'h008F, 1'b1);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'd2; b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("t3_latency", lat, 6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("t3_no_restart_c%0d", i), {31'd0, busy0 | done0}, 32'd0);
    end

    // Start held in DONE: straight back into CALC
    drive_start(8'd13, 8'd11, 16'h008F, 1'b1);
    wait_done(lat);
    chk("t4_first_latency", lat, 9);
    start = 1'b1; a = 8'd7; b = 8'd6;
    exp_q0.push_back(16'h002A);
    exp_q1.push_back(16'h002A);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("t4_no_idle_busy0", {31'd0, busy0}, 32'd1);
    chk("t4_no_idle_busy1", {31'd0, busy1}, 32'd1);
    chk("t4_product0_old", {16'd0, product0}, 32'h008F);
    wait_done(lat);
    chk("t4_second_latency", lat + 1, 9);
    @(negedge clk);

    // Reset in CALC cycle 4
    drive_start(8'd13, 8'd11, 16'h008F, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_busy0", {31'd0, busy0}, 32'd0);
    chk("t5_done0", {31'd0, done0}, 32'd0);
    chk("t5_product0", {16'd0, product0}, 32'd0);
    chk("t5_busy1", {31'd0, busy1}, 32'd0);
    chk("t5_product1", {16'd0, product1}, 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_start(8'd5, 8'd5, 16'h0019, 1'b1);
    wait_done(lat);
    chk("t5_restart_latency", lat, 9);
    chk("t5_restart_product0", {16'd0, product0}, 32'h0019);
    @(negedge clk);

    // Random pairs against a*b, mixing idle gaps and back-to-back starts
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i % 16 == 0) ra = 8'd0;
      drive_start(ra, rb, 16'(ra) * 16'(rb), 1'b1);
      wait_done(lat);
      if (lat != exp_lat(ra, rb)) chk("rand_latency", lat, exp_lat(ra, rb));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    chk("dut0_queue_drained", exp_q0.size(), 32'd0);
    chk("dut1_queue_drained", exp_q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Absolute time limit as a safety net.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
